// File: rtl/pipeline_barrier_pkg.sv
// +----------------------------------------------------------------------+
// | pipeline_pkg : shared FSM state type and default widths for barriers |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package pipeline_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } bar_state_e;

endpackage

`default_nettype wire

// File: rtl/pipeline_barrier_sat_counter.sv
// +----------------------------------------------------------------------+
// | sat_counter : up-counter that sticks at all-ones instead of wrapping |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sat_counter
    import pipeline_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (inc && (count_q != C_MAX)) begin
            count_q <= count_q + C_ONE;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_barrier.sv
// +----------------------------------------------------------------------+
// | pipeline_barrier : two-slot skid-buffered stage register with flush  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module pipeline_barrier
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [CNT_W-1:0]  bubble_count
);

    bar_state_e        state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q;
    logic              accept;
    logic              emit;

    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign emit      = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (accept && emit) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else if (accept) begin
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                    state_d     = TWO;
                end else if (emit) begin
                    main_ctrl_d = '0;
                    state_d     = EMPTY;
                end
            end
            TWO: begin
                if (emit) begin
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    skid_ctrl_d = '0;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // A kill overrides everything, including an accept in the same cycle.
        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= (state_d != TWO);
        end
    end

    // Payload slots carry no reset so they map onto plain flops.
    always_ff @(posedge clk) begin
        main_data_q <= main_data_d;
        skid_data_q <= skid_data_d;
    end

    assign in_ready = in_ready_q;
    assign out_data = main_data_q;
    assign out_ctrl = out_valid ? main_ctrl_q : '0;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_ready & ~out_valid),
        .count (bubble_count)
    );

endmodule

`default_nettype wire
